// File: rtl/random_digit_bank.sv
// random_digit_bank: NUM_CH independent channels. Each channel turns a rising
// trigger into one number in MIN_VAL..MAX_VAL. It draws from its own free-running
// 16-bit LFSR and rejects out-of-range candidates, with a bounded number of retries.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a rising trigger
// DRAW  | testing one LFSR candidate per edge until accept or fallback
//
// The parameters must satisfy MIN_VAL <= MAX_VAL < 2**DIGIT_W.
module random_digit_bank #(
  parameter int          NUM_CH    = 3,
  parameter int          DIGIT_W   = 4,
  parameter int          MIN_VAL   = 0,
  parameter int          MAX_VAL   = 9,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] SEED_BASE = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic [NUM_CH-1:0]               trigger,
  input  logic                            seed_load,
  input  logic [15:0]                     seed_value,
  output logic [NUM_CH-1:0][DIGIT_W-1:0]  numbers,
  output logic [NUM_CH-1:0]               valid,
  output logic [NUM_CH-1:0]               busy,
  output logic [NUM_CH-1:0]               overflow
);

  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

  localparam logic [DIGIT_W-1:0] SPAN      = DIGIT_W'(MAX_VAL - MIN_VAL);
  localparam logic [DIGIT_W-1:0] LOW       = DIGIT_W'(MIN_VAL);
  localparam logic [7:0]         TRY_LIMIT = 8'(MAX_TRIES);

  // Per-channel seed. A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] ch_seed(input logic [15:0] s, input int ch);
    logic [31:0] prod;
    logic [15:0] t;
    prod = 32'(ch) * 32'h0000_1F35;
    t    = s ^ prod[15:0];
    return (t == 16'h0000) ? 16'h0001 : t;
  endfunction

  logic [15:0]                     lfsr      [NUM_CH];
  state_t                          state_q   [NUM_CH];
  state_t                          state_nxt [NUM_CH];
  logic [7:0]                      try_q     [NUM_CH];
  logic [7:0]                      try_nxt   [NUM_CH];
  logic [NUM_CH-1:0]               trig_d;
  logic [NUM_CH-1:0]               req;
  logic [NUM_CH-1:0]               pend_q, pend_nxt;
  logic [NUM_CH-1:0]               ovf_nxt, valid_nxt;
  logic [NUM_CH-1:0][DIGIT_W-1:0]  num_nxt;
  logic                            done;
  logic [DIGIT_W-1:0]              cand;

  assign req = trigger & ~trig_d;

  // Free-running LFSRs, one per channel; seed_load reloads all of them.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int ch = 0; ch < NUM_CH; ch++) lfsr[ch] <= ch_seed(SEED_BASE, ch);
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (seed_load) lfsr[ch] <= ch_seed(seed_value, ch);
        else           lfsr[ch] <= {lfsr[ch][14:0],
                                    lfsr[ch][15] ^ lfsr[ch][13] ^ lfsr[ch][12] ^ lfsr[ch][10]};
      end
    end
  end

  // Trigger history for edge detection. It starts as all ones, so a trigger
  // held high through reset release does not count as a request.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) trig_d <= '1;
    else         trig_d <= trigger;
  end

  // Channel FSM registers and delivered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= IDLE;
        try_q[ch]   <= 8'd0;
      end
      pend_q   <= '0;
      overflow <= '0;
      valid    <= '0;
      numbers  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= state_nxt[ch];
        try_q[ch]   <= try_nxt[ch];
      end
      pend_q   <= pend_nxt;
      overflow <= ovf_nxt;
      valid    <= valid_nxt;
      numbers  <= num_nxt;
    end
  end

  // Next state: accept or reject one candidate, queue one extra request, flag drops.
  always_comb begin
    done = 1'b0;
    cand = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_nxt[ch] = state_q[ch];
      try_nxt[ch]   = try_q[ch];
      pend_nxt[ch]  = pend_q[ch];
      ovf_nxt[ch]   = overflow[ch];
      valid_nxt[ch] = 1'b0;
      num_nxt[ch]   = numbers[ch];
      done          = 1'b0;
      cand          = lfsr[ch][DIGIT_W-1:0];
      if (seed_load) begin
        state_nxt[ch] = IDLE;
        try_nxt[ch]   = 8'd0;
        pend_nxt[ch]  = 1'b0;
        ovf_nxt[ch]   = 1'b0;
      end else begin
        case (state_q[ch])
          IDLE: begin
            if (req[ch]) begin
              state_nxt[ch] = DRAW;
              try_nxt[ch]   = 8'd0;
            end
          end
          DRAW: begin
            if (cand <= SPAN) begin
              num_nxt[ch]   = LOW + cand;
              valid_nxt[ch] = 1'b1;
              done          = 1'b1;
            end else if (try_q[ch] == TRY_LIMIT) begin
              num_nxt[ch]   = LOW;
              valid_nxt[ch] = 1'b1;
              done          = 1'b1;
            end else begin
              try_nxt[ch] = try_q[ch] + 8'd1;
            end
            if (done) begin
              // A request arriving on the completion edge is queued, not dropped.
              if (pend_q[ch] || req[ch]) begin
                state_nxt[ch] = DRAW;
                try_nxt[ch]   = 8'd0;
                pend_nxt[ch]  = pend_q[ch] & req[ch];
              end else begin
                state_nxt[ch] = IDLE;
              end
            end else if (req[ch]) begin
              if (pend_q[ch]) ovf_nxt[ch]  = 1'b1;
              else            pend_nxt[ch] = 1'b1;
            end
          end
          default: state_nxt[ch] = IDLE;
        endcase
      end
    end
  end

  // busy mirrors the DRAW state.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) busy[ch] = (state_q[ch] == DRAW);
  end

endmodule

// File: doc/random_digit_bank.md
RANDOM_DIGIT_BANK -- requirements
Module: random_digit_bank

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent random channels (1..16).
REQ-002 Parameter DIGIT_W, default 4: width of each output number (1..15).
REQ-003 Parameter MIN_VAL, default 0: lowest output value; MIN_VAL <= MAX_VAL < 2^DIGIT_W is a required parameter condition.
REQ-004 Parameter MAX_VAL, default 9: highest output value.
REQ-005 Parameter MAX_TRIES, default 8: rejected draws allowed before fallback (1..255).
REQ-006 Parameter SEED_BASE, default 16'hACE1: base LFSR seed.
REQ-007 clk  in  1  single clock; all state on posedge clk.
REQ-008 resetN  in  1  asynchronous active-low reset.
REQ-009 trigger  in  [NUM_CH-1:0]  per-channel request; rising edge requests one number.
REQ-010 seed_load  in  1  one-cycle pulse; reseeds all channels.
REQ-011 seed_value  in  16  seed used by seed_load.
REQ-012 numbers  out  [NUM_CH-1:0][DIGIT_W-1:0]  last delivered number per channel.
REQ-013 valid  out  [NUM_CH-1:0]  one-cycle pulse when numbers[ch] updates.
REQ-014 busy  out  [NUM_CH-1:0]  channel in DRAW state.
REQ-015 overflow  out  [NUM_CH-1:0]  sticky flag; a request was dropped.

Function
REQ-016 Each channel SHALL own a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1: shift left, bit0 <= b15^b13^b12^b10, advancing every cycle unconditionally.
REQ-017 Channel seed SHALL be S ^ (ch * 16'h1F35) truncated to 16 bits, where S = SEED_BASE at reset and S = seed_value on seed_load; a zero result SHALL be replaced by 16'h0001.
REQ-018 trig_d SHALL register trigger each cycle; a request for ch is trigger[ch]=1 and trig_d[ch]=0 at a clock edge.
REQ-019 Per-channel FSM states IDLE and DRAW; busy[ch]=1 exactly in DRAW.
REQ-020 IDLE + request -> DRAW; try counter <= 0.
REQ-021 In DRAW, each edge SHALL test candidate c = lfsr[DIGIT_W-1:0]: if c <= MAX_VAL-MIN_VAL, then numbers[ch] <= MIN_VAL + c, valid[ch] <= 1, and the FSM leaves DRAW.
REQ-022 On rejection, the try counter SHALL increment; when the counter reaches MAX_TRIES with a reject, numbers[ch] <= MIN_VAL, valid[ch] <= 1, and the FSM leaves DRAW.
REQ-023 Latency SHALL be one edge minimum (request at edge k, valid at edge k+1) and MAX_TRIES+1 edges maximum.
REQ-024 A request while in DRAW SHALL set pending[ch]; on leaving DRAW with pending set, the FSM re-enters DRAW (try counter 0, pending cleared), else it returns to IDLE.
REQ-025 A request while in DRAW with pending already set SHALL be dropped and SHALL set overflow[ch].
REQ-026 A request on the same edge as DRAW completion SHALL be treated as pending (re-enter DRAW), not dropped.
REQ-027 Channels SHALL be fully independent; simultaneous requests on all channels SHALL all be served.
REQ-028 seed_load SHALL reseed all LFSRs, force all FSMs to IDLE, and clear pending, overflow and valid.
REQ-029 seed_load SHALL leave numbers unchanged and SHALL ignore requests on the same edge, while trig_d still updates.
REQ-030 valid SHALL deassert on the cycle after its pulse unless a new number is delivered.

Reset
REQ-031 On resetN=0, asynchronously: numbers=0, valid=0, busy=0, overflow=0, pending=0, FSMs IDLE, LFSRs to SEED_BASE channel seeds, trig_d all ones.
REQ-032 A trigger held high through reset release SHALL NOT generate a request.
REQ-033 Reset asserted mid-DRAW SHALL abort the draw without a valid pulse.

Verification
REQ-034 Defaults, reset release, trigger[0] 0->1 -> valid[0] within 1..9 edges, numbers[0] in 0..9, matching the bit-exact LFSR model from seed 16'hACE1.
REQ-035 MIN_VAL=MAX_VAL=5, repeated triggers on all channels -> every valid carries 5, latency <= MAX_TRIES+1.
REQ-036 Three rising edges on ch1 during one DRAW -> exactly two valid pulses on ch1, overflow[1]=1; other channels unaffected.
REQ-037 seed_load with seed_value=16'h0000 -> ch0 LFSR = 16'h0001, busy cleared, overflow cleared, numbers retained; identical sequences after two loads of the same seed.
REQ-038 trigger high during and after reset release -> no valid pulse; resetN pulsed mid-DRAW -> all outputs 0 immediately.
REQ-039 Statistical run, 10000 draws per channel, defaults -> each value 0..9 within +/-15% of uniform count and fallback rate below 1%.
